// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - regfile write-port arbiter: writeback priority, multi-cycle result FIFO, WAW kill, starvation stall
module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  input  logic [4:0]  q_addr0,
  input  logic [4:0]  q_addr1,
  output logic        q_busy0,
  output logic        q_busy1,
  output logic        stall_req,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]       fifo_addr [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [DEPTH-1:0] fifo_vld;
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count, count_next;
  logic [SW-1:0]    starve_cnt, starve_next;
  logic             stall_next;

  logic wb_eff, head_live, grant_head, pop, push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Grant decision and FIFO push/pop qualifiers; a killed head is popped without using the port
  always_comb begin
    wb_eff     = wb_valid && (wb_addr != 5'd0);
    md_ready   = (count != CW'(DEPTH));
    head_live  = (count != '0) && fifo_vld[rd_ptr];
    grant_head = !wb_eff && head_live;
    pop        = (count != '0) && (grant_head || !fifo_vld[rd_ptr]);
    push       = md_valid && md_ready && (md_addr != 5'd0);
    count_next = count + CW'(push) - CW'(pop);
  end

  // Starvation counter and stall request next-state
  always_comb begin
    starve_next = starve_cnt;
    stall_next  = stall_req;
    if (grant_head || count_next == '0) begin
      starve_next = '0;
      stall_next  = 1'b0;
    end else begin
      if (head_live && wb_eff && starve_cnt != SW'(STARVE_MAX))
        starve_next = starve_cnt + 1'b1;
      if (starve_next == SW'(STARVE_MAX))
        stall_next = 1'b1;
    end
  end

  // FIFO storage: kill older matching entries, then pop, then push (push wins so the younger entry survives)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_vld <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wb_eff && fifo_vld[i] && fifo_addr[i] == wb_addr)
          fifo_vld[i] <= 1'b0;
      if (pop) begin
        fifo_vld[rd_ptr] <= 1'b0;
        rd_ptr           <= ptr_inc(rd_ptr);
      end
      if (push) begin
        fifo_vld[wr_ptr]  <= 1'b1;
        fifo_addr[wr_ptr] <= md_addr;
        fifo_data[wr_ptr] <= md_data;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      count <= count_next;
    end
  end

  // Starvation state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      stall_req  <= stall_next;
    end
  end

  // Registered regfile write port from the granted source; address/data hold when idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (wb_eff) begin
      rf_we    <= 1'b1;
      rf_waddr <= wb_addr;
      rf_wdata <= wb_data;
    end else if (grant_head) begin
      rf_we    <= 1'b1;
      rf_waddr <= fifo_addr[rd_ptr];
      rf_wdata <= fifo_data[rd_ptr];
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Hazard queries: any live entry targeting a non-zero query address
  always_comb begin
    q_busy0 = 1'b0;
    q_busy1 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i] && fifo_addr[i] == q_addr0 && q_addr0 != 5'd0) q_busy0 = 1'b1;
      if (fifo_vld[i] && fifo_addr[i] == q_addr1 && q_addr1 != 5'd0) q_busy1 = 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

  logic        clk;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic [4:0]  q_addr0;
  logic [4:0]  q_addr1;
  logic        q_busy0;
  logic        q_busy1;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_vec;
  int n_bad;

  wb_port_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .md_valid  (md_valid),
    .md_ready  (md_ready),
    .md_addr   (md_addr),
    .md_data   (md_data),
    .q_addr0   (q_addr0),
    .q_addr1   (q_addr1),
    .q_busy0   (q_busy0),
    .q_busy1   (q_busy1),
    .stall_req (stall_req),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb_valid = v; wb_addr = a; wb_data = d;
  endtask

  task automatic set_md(input logic v, input logic [4:0] a, input logic [31:0] d);
    md_valid = v; md_addr = a; md_data = d;
  endtask

  task automatic check_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    check({tag, ".we"}, rf_we, we);
    if (we) begin
      check({tag, ".addr"}, rf_waddr, a);
      check({tag, ".data"}, rf_wdata, d);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    set_wb(0, 0, 0);
    set_md(0, 0, 0);
    q_addr0 = 0;
    q_addr1 = 0;
    #2;
    check("rst.rf_we", rf_we, 0);
    check("rst.rf_waddr", rf_waddr, 0);
    check("rst.rf_wdata", rf_wdata, 0);
    check("rst.md_ready", md_ready, 1);
    check("rst.stall", stall_req, 0);
    tick();
    reset = 1'b0;
    tick();

    // Idle drain: accept at an edge, write one edge later, busy in between
    q_addr0 = 5;
    set_md(1, 5, 32'hDEADBEEF);
    tick();
    set_md(0, 0, 0);
    #1;
    check("drain.busy", q_busy0, 1);
    check("drain.we_early", rf_we, 0);
    tick();
    check_rf("drain.wr", 1, 5, 32'hDEADBEEF);
    check("drain.busy_after", q_busy0, 0);
    tick();
    check("drain.idle_we", rf_we, 0);
    check("drain.hold_addr", rf_waddr, 5);
    check("drain.hold_data", rf_wdata, 32'hDEADBEEF);

    // Starvation: wb hogs the port, stall after four denied cycles
    set_wb(1, 3, 32'h33);
    set_md(1, 7, 32'h1234);
    tick();
    set_md(0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_rf($sformatf("starve.wb%0d", i), 1, 3, 32'h33);
      check($sformatf("starve.stall%0d", i), stall_req, (i == 4) ? 1 : 0);
    end
    set_wb(0, 0, 0);
    tick();
    check_rf("starve.head", 1, 7, 32'h1234);
    check("starve.stall_fall", stall_req, 0);
    tick();
    check("starve.idle", rf_we, 0);

    // WAW kill: newer wb write to the same register kills the queued one
    set_wb(1, 3, 32'h33);
    set_md(1, 9, 32'hAAAA);
    q_addr0 = 9;
    tick();
    set_md(0, 0, 0);
    set_wb(1, 9, 32'hBBBB);
    #1;
    check("waw.busy_before", q_busy0, 1);
    tick();
    set_wb(0, 0, 0);
    check_rf("waw.wb", 1, 9, 32'hBBBB);
    check("waw.busy_after", q_busy0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("waw.no_stale%0d", i), rf_we, 0);
    end

    // Full / backpressure: third result held until space frees
    set_wb(1, 3, 32'h33);
    set_md(1, 4, 32'h44);
    tick();
    set_md(1, 6, 32'h66);
    tick();
    set_md(1, 8, 32'h88);
    #1;
    check("full.ready0", md_ready, 0);
    tick();
    check("full.ready1", md_ready, 0);
    set_wb(0, 0, 0);
    tick();
    check_rf("full.w4", 1, 4, 32'h44);
    check("full.ready_free", md_ready, 1);
    tick();
    set_md(0, 0, 0);
    check_rf("full.w6", 1, 6, 32'h66);
    tick();
    check_rf("full.w8", 1, 8, 32'h88);
    tick();
    check("full.idle", rf_we, 0);

    // Zero addresses: md to r0 dropped, wb to r0 does not take the port
    q_addr1 = 0;
    set_md(1, 0, 32'hFF);
    #1;
    check("zero.ready", md_ready, 1);
    tick();
    set_md(0, 0, 0);
    check("zero.busy_r0", q_busy1, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("zero.md_drop%0d", i), rf_we, 0);
    end
    set_md(1, 10, 32'hA0);
    set_wb(1, 3, 32'h33);
    tick();
    set_md(0, 0, 0);
    set_wb(1, 0, 32'h99);
    tick();
    set_wb(0, 0, 0);
    check_rf("zero.wb_r0", 1, 10, 32'hA0);

    // Reset mid-operation with two queued entries and stall raised
    q_addr0 = 11;
    set_wb(1, 3, 32'h33);
    set_md(1, 11, 32'hB1);
    tick();
    set_md(1, 12, 32'hB2);
    tick();
    set_md(0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    check("mid.stall_pre", stall_req, 1);
    check("mid.ready_pre", md_ready, 0);
    check("mid.busy_pre", q_busy0, 1);
    set_wb(0, 0, 0);
    reset = 1'b1;
    #1;
    check("mid.ready", md_ready, 1);
    check("mid.stall", stall_req, 0);
    check("mid.rf_we", rf_we, 0);
    check("mid.busy", q_busy0, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("mid.no_stale%0d", i), rf_we, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
